imm_ext_arbiter: RTL and testbench
==================================

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter: SHIFT_BR, default 1, when 1 the CB and B format results SHALL be shifted left by 2 after extension.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; the block SHALL be in reset on any rising clk edge where reset=0.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an instruction.
REQ-005 req0_instr / req1_instr  input  32 each  raw instruction word.
REQ-006 req0_fmt / req1_fmt  input  2 each  immediate format: 00 D, 01 CB, 10 B, 11 I.
REQ-007 req0_ready / req1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-008 out_valid  output  1  out_imm, out_id and out_fmt hold a result.
REQ-009 out_ready  input  1  consumer takes the result when out_valid&out_ready.
REQ-010 out_imm  output  64  extended immediate.
REQ-011 out_id  output  1  index of the requester that produced out_imm.
REQ-012 out_fmt  output  2  format of out_imm.
REQ-013 acc0_cnt / acc1_cnt  output  16 each  accepted-transaction counters.

Function
REQ-014 Extraction and extension SHALL work as follows:
- D: instr[20:12] sign-extended from 9 bits.
- CB: instr[23:5] sign-extended from 19 bits.
- B: instr[25:0] sign-extended from 26 bits.
- I: instr[21:10] zero-extended from 12 bits.
REQ-015 When SHIFT_BR=1, CB and B results SHALL be shifted left 2 within 64 bits; bits shifted out of [63] SHALL be discarded.
REQ-016 The output register SHALL be a two-state machine. EMPTY (out_valid=0) goes to FULL on accept. FULL stays FULL on drain plus accept in the same cycle. FULL goes to EMPTY on drain with no accept. FULL holds when out_ready=0.
REQ-017 can_accept SHALL equal (state==EMPTY) or (out_valid and out_ready).
REQ-018 Arbitration SHALL be round-robin using a 1-bit last-grant pointer:
- Only one valid: that requester is granted.
- Both valid: the requester other than the last grant is granted.
- Neither valid: no grant.
REQ-019 reqN_ready SHALL equal grantN and can_accept, combinationally; at most one ready SHALL be high per cycle.
REQ-020 On accept, the extended result SHALL appear on out_imm with out_valid=1 at the next rising edge (latency 1 cycle).
REQ-021 The pointer SHALL update to the granted index only on accept.
REQ-022 While FULL and out_ready=0, out_imm, out_id and out_fmt SHALL stay stable, and both readys SHALL be 0.
REQ-023 A non-granted valid requester SHALL keep its request; the block SHALL NOT drop it.
REQ-024 accN_cnt SHALL increment by 1 on each accept from requester N and SHALL saturate at 16'hFFFF.
REQ-025 Changes to reqN_instr or reqN_fmt while valid and not ready SHALL have no effect on state.

Reset
REQ-026 On reset: state EMPTY, out_valid=0, out_imm=0, out_id=0, out_fmt=00, last-grant pointer=1 (req0 wins first contention), acc0_cnt=0, acc1_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard any held result at that edge, regardless of out_ready or request inputs.
REQ-028 Readys SHALL be 0 in any cycle where reset=0.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- D format: req0 D, instr[20:12]=9'h100, out_ready=1 -> next cycle out_valid=1, out_imm=64'hFFFF_FFFF_FFFF_FF00, out_id=0, acc0_cnt=1.
- CB format: req1 CB, instr[23:5]=19'h7FFFF, SHIFT_BR=1 -> out_imm=64'hFFFF_FFFF_FFFF_FFFC, out_id=1.
- B and I formats: req0 B, instr[25:0]=26'h3000000 -> 64'hFFFF_FFFF_FC00_0000; req0 I, instr[21:10]=12'hFFF -> 64'h0000_0000_0000_0FFF.
- Contention: both valid every cycle, out_ready=1, from reset -> out_id sequence 0,1,0,1; after 4 accepts acc0_cnt=2, acc1_cnt=2.
- Backpressure then reset: out_ready=0 with FULL for 3 cycles -> out_imm unchanged, req0_ready=req1_ready=0; then reset=0 for one edge -> out_valid=0, counters=0.
- Counter saturation: force 65,536 req0 accepts -> acc0_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin two-requester immediate extender with a one-entry output register
module imm_ext_arbiter #(
  parameter bit SHIFT_BR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_instr,
  input  logic [1:0]  req0_fmt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_instr,
  input  logic [1:0]  req1_fmt,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_imm,
  output logic        out_id,
  output logic [1:0]  out_fmt,
  output logic [15:0] acc0_cnt,
  output logic [15:0] acc1_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic last, g0, g1, can_accept, acc0, acc1, acc;
  logic [31:0] sel_instr;
  logic [1:0] sel_fmt;
  logic [63:0] ext, imm;
  assign out_valid = (state == FULL);
  // grant, handshake, extraction and next-state selection
  always_comb begin
    g0 = req0_valid & (~req1_valid | last);
    g1 = req1_valid & (~req0_valid | ~last);
    can_accept = (state == EMPTY) | (out_valid & out_ready);
    req0_ready = reset & g0 & can_accept;
    req1_ready = reset & g1 & can_accept;
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    acc = acc0 | acc1;
    sel_instr = acc1 ? req1_instr : req0_instr;
    sel_fmt = acc1 ? req1_fmt : req0_fmt;
    ext = (sel_fmt == 2'b00) ? {{55{sel_instr[20]}}, sel_instr[20:12]} :
          (sel_fmt == 2'b01) ? {{45{sel_instr[23]}}, sel_instr[23:5]} :
          (sel_fmt == 2'b10) ? {{38{sel_instr[25]}}, sel_instr[25:0]} :
                               {52'b0, sel_instr[21:10]};
    imm = (SHIFT_BR && (sel_fmt == 2'b01 || sel_fmt == 2'b10)) ? {ext[61:0], 2'b00} : ext;
    state_nx = acc ? FULL : (out_valid & out_ready) ? EMPTY : state;
  end
  // output-register state
  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else state <= state_nx;
  end
  // result capture, grant pointer and saturating accept counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_imm <= '0;
      out_id <= 1'b0;
      out_fmt <= 2'b00;
      last <= 1'b1;
      acc0_cnt <= '0;
      acc1_cnt <= '0;
    end else begin
      if (acc) begin
        out_imm <= imm;
        out_id <= acc1;
        out_fmt <= sel_fmt;
        last <= acc1;
      end
      acc0_cnt <= acc0_cnt + {15'b0, acc0 & ~&acc0_cnt};
      acc1_cnt <= acc1_cnt + {15'b0, acc1 & ~&acc1_cnt};
    end
  end
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed table plus hand sequences for imm_ext_arbiter
module tb_imm_ext_arbiter;
  logic clk = 0, reset = 0;
  logic req0_valid = 0, req1_valid = 0, out_ready = 0;
  logic [31:0] req0_instr = 0, req1_instr = 0;
  logic [1:0] req0_fmt = 0, req1_fmt = 0;
  logic req0_ready, req1_ready, out_valid, out_id;
  logic [63:0] out_imm;
  logic [1:0] out_fmt;
  logic [15:0] acc0_cnt, acc1_cnt;
  int n_chk = 0, n_bad = 0;

  imm_ext_arbiter #(.SHIFT_BR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_fmt(req0_fmt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_fmt(req1_fmt), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_id(out_id),
    .out_fmt(out_fmt), .acc0_cnt(acc0_cnt), .acc1_cnt(acc1_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic [31:0] i0; logic [1:0] f0;
    logic v1; logic [31:0] i1; logic [1:0] f1;
    logic ordy;
    logic r0, r1, ov; logic [63:0] imm; logic id; logic [1:0] fmt;
    logic [15:0] c0, c1;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] i0, input logic [1:0] f0,
                       input logic v1, input logic [31:0] i1, input logic [1:0] f1, input logic ordy);
    req0_valid = v0; req0_instr = i0; req0_fmt = f0;
    req1_valid = v1; req1_instr = i1; req1_fmt = f1;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    tv[0] = '{1, 32'h0010_0000, 0, 0, 0, 0, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF00, 0, 0, 1, 0};
    tv[1] = '{0, 0, 0, 1, 32'h00FF_FFE0, 1, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1, 1};
    tv[2] = '{1, 32'h0300_0000, 2, 0, 0, 0, 1, 1, 0, 1, 64'hFFFF_FFFF_FC00_0000, 0, 2, 2, 1};
    tv[3] = '{1, 32'h003F_FC00, 3, 0, 0, 0, 1, 1, 0, 1, 64'h0000_0000_0000_0FFF, 0, 3, 3, 1};
    tv[4] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0, 0, 0, 3, 1};
    tv[5] = '{1, 32'h000F_F000, 0, 1, 32'h00FF_FFE0, 1, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 3, 2};
    tv[6] = '{1, 32'h000F_F000, 0, 1, 32'h00FF_FFE0, 1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 3, 2};
    tv[7] = '{1, 32'hFFC0_0000, 3, 1, 32'h00FF_FFE0, 1, 1, 1, 0, 1, 64'h0, 0, 3, 4, 2};
    tv[8] = '{1, 32'hFFC0_0000, 3, 1, 32'h00FF_FFE0, 1, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 4, 3};
    tv[9] = '{0, 0, 0, 1, 32'h0100_0000, 2, 1, 0, 1, 1, 64'h0000_0000_0400_0000, 1, 2, 4, 4};

    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_id", out_id, 0);
    chk("rst_fmt", out_fmt, 0);
    chk("rst_c0", acc0_cnt, 0);
    chk("rst_c1", acc1_cnt, 0);

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(tv[k].v0, tv[k].i0, tv[k].f0, tv[k].v1, tv[k].i1, tv[k].f1, tv[k].ordy);
      #1;
      chk($sformatf("v%0d_r0", k), req0_ready, tv[k].r0);
      chk($sformatf("v%0d_r1", k), req1_ready, tv[k].r1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", k), out_valid, tv[k].ov);
      if (tv[k].ov) begin
        chk($sformatf("v%0d_imm", k), out_imm, tv[k].imm);
        chk($sformatf("v%0d_id", k), out_id, tv[k].id);
        chk($sformatf("v%0d_fmt", k), out_fmt, tv[k].fmt);
      end
      chk($sformatf("v%0d_c0", k), acc0_cnt, tv[k].c0);
      chk($sformatf("v%0d_c1", k), acc1_cnt, tv[k].c1);
    end

    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 32'h000F_F000, 0, 1, 32'h003F_FC00, 3, 1);
      #1;
      chk($sformatf("rr%0d_r0", k), req0_ready, (k % 2 == 0));
      chk($sformatf("rr%0d_r1", k), req1_ready, (k % 2 == 1));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_id", k), out_id, (k % 2 == 1));
      chk($sformatf("rr%0d_imm", k), out_imm, (k % 2 == 1) ? 64'hFFF : 64'hFF);
    end
    chk("rr_c0", acc0_cnt, 2);
    chk("rr_c1", acc1_cnt, 2);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 32'h0010_0000, 0, 1, 32'h00FF_FFE0, 1, 0);
      #1;
      chk($sformatf("bp%0d_r0", k), req0_ready, 0);
      chk($sformatf("bp%0d_r1", k), req1_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_ov", k), out_valid, 1);
      chk($sformatf("bp%0d_imm", k), out_imm, 64'hFFF);
      chk($sformatf("bp%0d_id", k), out_id, 1);
    end
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    #1;
    chk("inrst_r0", req0_ready, 0);
    chk("inrst_r1", req1_ready, 0);
    @(posedge clk); #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_c0", acc0_cnt, 0);
    chk("mrst_c1", acc1_cnt, 0);
    @(negedge clk);
    reset = 1;

    do_reset();
    @(negedge clk);
    drive(1, 32'h003F_FC00, 3, 0, 0, 0, 1);
    repeat (65536) @(posedge clk);
    #1;
    chk("sat_c0", acc0_cnt, 16'hFFFF);
    chk("sat_c1", acc1_cnt, 0);
    @(posedge clk); #1;
    chk("sat_hold_c0", acc0_cnt, 16'hFFFF);
    chk("sat_ov", out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
